// File: rtl/clock_pkg.sv
// Shared mode encodings and BCD constants for the HH:MM:SS time-set controller.
// Rev 1.0
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET_H = 2'b01,
        MODE_SET_M = 2'b10,
        MODE_SET_S = 2'b11
    } mode_t;

    localparam logic [7:0] BCD_ZERO   = 8'h00;
    localparam logic [7:0] BCD_H_LIM  = 8'h23;
    localparam logic [7:0] BCD_MS_LIM = 8'h59;

endpackage

`default_nettype wire

// File: rtl/bcd2_inc.sv
// bcd2_inc: combinational 2-digit BCD increment, wrapping to 00 at the limit.
// Rev 1.0
`default_nettype none

module bcd2_inc
    import clock_pkg::*;
(
    input  logic [7:0] in,
    input  logic [7:0] lim,
    output logic [7:0] out
);

    always_comb begin
        out = BCD_ZERO;
        // Non-BCD digits or anything at/above the limit wrap straight to zero.
        if ((in[3:0] > 4'd9) || (in[7:4] > 4'd9) || (in >= lim)) begin
            out = BCD_ZERO;
        end else if (in[3:0] == 4'd9) begin
            out = {in[7:4] + 4'd1, 4'd0};
        end else begin
            out = {in[7:4], in[3:0] + 4'd1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-set sequencer; edits shadow time and loads the counters.
// Optional macro CLOCK_SET_BLINK_EN enables the edited-field blink toggle. Rev 1.0
`default_nettype none

module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter logic [7:0] H_LIM  = BCD_H_LIM,
    parameter logic [7:0] MS_LIM = BCD_MS_LIM,
    parameter int         SYNC_N = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_add,
    input  logic [7:0] cur_s,
    input  logic [7:0] cur_m,
    input  logic [7:0] cur_h,
    output logic       ld_s,
    output logic       ld_m,
    output logic       ld_h,
    output logic [7:0] d_s,
    output logic [7:0] d_m,
    output logic [7:0] d_h,
    output logic       run_en,
    output logic [1:0] mode,
    output logic       blink
);

    logic [SYNC_N-1:0] r_sync_mode;
    logic [SYNC_N-1:0] r_sync_add;
    logic              r_prev_mode;
    logic              r_prev_add;
    logic              w_mode_p;
    logic              w_add_p;

    mode_t      r_state, w_state_nxt;
    logic [7:0] r_sh_h, r_sh_m, r_sh_s;
    logic [7:0] w_sh_h_nxt, w_sh_m_nxt, w_sh_s_nxt;
    logic       r_ld, w_ld_nxt;
    logic       r_run_en, w_run_en_nxt;
    logic [7:0] w_inc_in, w_inc_lim, w_inc_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_mode <= '0;
            r_sync_add  <= '0;
            r_prev_mode <= 1'b0;
            r_prev_add  <= 1'b0;
        end else begin
            r_sync_mode <= {r_sync_mode[SYNC_N-2:0], btn_mode};
            r_sync_add  <= {r_sync_add[SYNC_N-2:0], btn_add};
            r_prev_mode <= r_sync_mode[SYNC_N-1];
            r_prev_add  <= r_sync_add[SYNC_N-1];
        end
    end

    assign w_mode_p = r_sync_mode[SYNC_N-1] & ~r_prev_mode;
    assign w_add_p  = r_sync_add[SYNC_N-1] & ~r_prev_add;

    // One shared incrementer, fed with whichever field is being edited.
    always_comb begin
        w_inc_in  = r_sh_s;
        w_inc_lim = MS_LIM;
        case (r_state)
            MODE_SET_H: begin w_inc_in = r_sh_h; w_inc_lim = H_LIM; end
            MODE_SET_M: w_inc_in = r_sh_m;
            default:    w_inc_in = r_sh_s;
        endcase
    end

    bcd2_inc u_inc (
        .in  (w_inc_in),
        .lim (w_inc_lim),
        .out (w_inc_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MODE_RUN;
            r_sh_h   <= BCD_ZERO;
            r_sh_m   <= BCD_ZERO;
            r_sh_s   <= BCD_ZERO;
            r_ld     <= 1'b0;
            r_run_en <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_sh_h   <= w_sh_h_nxt;
            r_sh_m   <= w_sh_m_nxt;
            r_sh_s   <= w_sh_s_nxt;
            r_ld     <= w_ld_nxt;
            r_run_en <= w_run_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sh_h_nxt   = r_sh_h;
        w_sh_m_nxt   = r_sh_m;
        w_sh_s_nxt   = r_sh_s;
        w_ld_nxt     = 1'b0;
        w_run_en_nxt = r_run_en | r_ld;
        // mode_p has priority; add_p is only honoured when no mode press.
        case (r_state)
            MODE_RUN: begin
                if (w_mode_p) begin
                    w_sh_h_nxt   = cur_h;
                    w_sh_m_nxt   = cur_m;
                    w_sh_s_nxt   = cur_s;
                    w_state_nxt  = MODE_SET_H;
                    w_run_en_nxt = 1'b0;
                end
            end
            MODE_SET_H: begin
                if (w_mode_p)     w_state_nxt = MODE_SET_M;
                else if (w_add_p) w_sh_h_nxt  = w_inc_out;
            end
            MODE_SET_M: begin
                if (w_mode_p)     w_state_nxt = MODE_SET_S;
                else if (w_add_p) w_sh_m_nxt  = w_inc_out;
            end
            default: begin
                if (w_mode_p) begin
                    w_state_nxt = MODE_RUN;
                    w_ld_nxt    = 1'b1;
                end else if (w_add_p) begin
                    w_sh_s_nxt = w_inc_out;
                end
            end
        endcase
    end

    assign ld_h   = r_ld;
    assign ld_m   = r_ld;
    assign ld_s   = r_ld;
    assign d_h    = r_sh_h;
    assign d_m    = r_sh_m;
    assign d_s    = r_sh_s;
    assign run_en = r_run_en;
    assign mode   = r_state;

`ifdef CLOCK_SET_BLINK_EN
    logic r_blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= 1'b0;
        end else if ((r_state == MODE_RUN) || w_mode_p) begin
            r_blink <= 1'b0;
        end else if (tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign blink = r_blink;
`else
    // tick only feeds the blink timebase, which is absent in this build.
    assign blink = 1'b0 & tick;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed stimulus with a load scoreboard for clock_set_ctrl.
// Rev 1.0
`default_nettype none

module tb_clock_set_ctrl;

    localparam int SYNC_N = 2;
`ifdef CLOCK_SET_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_add = 1'b0;
    logic [7:0] cur_s = 8'h56;
    logic [7:0] cur_m = 8'h34;
    logic [7:0] cur_h = 8'h12;
    logic       ld_s, ld_m, ld_h;
    logic [7:0] d_s, d_m, d_h;
    logic       run_en;
    logic [1:0] mode;
    logic       blink;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];
    logic        r_chk_after = 1'b0;
    logic        exp_blink;

    clock_set_ctrl #(.H_LIM(8'h23), .MS_LIM(8'h59), .SYNC_N(SYNC_N)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_mode(btn_mode), .btn_add(btn_add),
        .cur_s(cur_s), .cur_m(cur_m), .cur_h(cur_h),
        .ld_s(ld_s), .ld_m(ld_m), .ld_h(ld_h),
        .d_s(d_s), .d_m(d_m), .d_h(d_h),
        .run_en(run_en), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic m, input logic a);
        @(negedge clk);
        btn_mode = m;
        btn_add  = a;
        repeat (SYNC_N + 3) @(negedge clk);
        btn_mode = 1'b0;
        btn_add  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Monitor: every ld pulse must match the oldest queued expected load.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (r_chk_after) begin
                    chk("ld_one_cycle", {21'd0, ld_h, ld_m, ld_s}, 24'd0);
                    chk("run_en_after_ld", {23'd0, run_en}, 24'd1);
                    r_chk_after = 1'b0;
                end else if (ld_h | ld_m | ld_s) begin
                    chk("ld_all_three", {21'd0, ld_h, ld_m, ld_s}, 24'd7);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ld: got d=%h%h%h expected no load", d_h, d_m, d_s);
                    end else begin
                        e = exp_q.pop_front();
                        chk("load_value", {d_h, d_m, d_s}, e);
                        chk("run_en_during_ld", {23'd0, run_en}, 24'd0);
                        chk("mode_during_ld", {22'd0, mode}, 24'd0);
                    end
                    r_chk_after = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_mode", {22'd0, mode}, 24'd0);
        chk("rst_run_en", {23'd0, run_en}, 24'd1);
        chk("rst_ld", {21'd0, ld_h, ld_m, ld_s}, 24'd0);
        chk("rst_d", {d_h, d_m, d_s}, 24'h000000);
        chk("rst_blink", {23'd0, blink}, 24'd0);

        // Capture 12:34:56, bump hours three times, load
        press(1'b1, 1'b0);
        chk("enter_mode", {22'd0, mode}, 24'd1);
        chk("enter_run_en", {23'd0, run_en}, 24'd0);
        chk("shadow_copy", {d_h, d_m, d_s}, 24'h123456);
        repeat (3) press(1'b0, 1'b1);
        chk("hours_plus3", {16'd0, d_h}, 24'h15);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("set_s_mode", {22'd0, mode}, 24'd3);
        exp_q.push_back(24'h153456);
        press(1'b1, 1'b0);
        chk("after_load_mode", {22'd0, mode}, 24'd0);
        chk("after_load_d", {d_h, d_m, d_s}, 24'h153456);

        // Wraps and digit carry
        cur_h = 8'h22; cur_m = 8'h59; cur_s = 8'h09;
        press(1'b1, 1'b0);
        chk("copy_22", {16'd0, d_h}, 24'h22);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("hour_wrap", {16'd0, d_h}, 24'h00);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("min_wrap", {d_h, d_m}, 24'h0000);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("sec_carry", {16'd0, d_s}, 24'h10);
        exp_q.push_back(24'h000010);
        press(1'b1, 1'b1);
        chk("both_mode", {22'd0, mode}, 24'd0);
        chk("both_value", {16'd0, d_s}, 24'h10);

        // add in RUN is ignored
        press(1'b0, 1'b1);
        chk("add_in_run", {d_h, d_m, d_s}, 24'h000010);
        chk("add_in_run_mode", {22'd0, mode}, 24'd0);

        // Out-of-range capture wraps on first add
        cur_h = 8'h6A;
        press(1'b1, 1'b0);
        chk("copy_6a", {16'd0, d_h}, 24'h6A);
        press(1'b0, 1'b1);
        chk("oor_wrap", {16'd0, d_h}, 24'h00);
        press(1'b1, 1'b0);
        chk("in_set_m", {22'd0, mode}, 24'd2);

        // Reset while editing
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_edit_mode", {22'd0, mode}, 24'd0);
        chk("rst_edit_run_en", {23'd0, run_en}, 24'd1);
        chk("rst_edit_d", {d_h, d_m, d_s}, 24'h000000);
        chk("rst_edit_ld", {21'd0, ld_h, ld_m, ld_s}, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Blink behaviour
        cur_h = 8'h01; cur_m = 8'h02; cur_s = 8'h03;
        press(1'b1, 1'b0);
        exp_blink = 1'b0;
        chk("blink_enter", {23'd0, blink}, {23'd0, exp_blink});
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            exp_blink = BLINK_ON & ~exp_blink;
            chk("blink_tick", {23'd0, blink}, {23'd0, exp_blink});
        end
        press(1'b1, 1'b0);
        pulse_tick();
        chk("blink_set_m", {23'd0, blink}, {23'd0, BLINK_ON});
        press(1'b1, 1'b0);
        chk("blink_mode_clear", {23'd0, blink}, 24'd0);
        exp_q.push_back(24'h010203);
        press(1'b1, 1'b0);
        chk("blink_run", {23'd0, blink}, 24'd0);
        pulse_tick();
        chk("blink_run_tick", {23'd0, blink}, 24'd0);
        chk("load_010203", {d_h, d_m, d_s}, 24'h010203);

        repeat (3) @(negedge clk);
        chk("loads_pending", exp_q.size(), 24'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
